// File: rtl/cenn_pkg.sv
// Shared definitions for the CeNN cell: template address map, fixed-point
// unity and the saturate/clamp helpers used by every arithmetic stage.
package cenn_pkg;

  localparam int FX_FRAC  = 9;
  localparam int TPL_B0   = 9;
  localparam int TPL_I    = 18;
  localparam int TPL_H    = 19;
  localparam int TPL_LAST = 19;

  function automatic longint fx_one(input int frac);
    return 64'sd1 <<< frac;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                               input logic signed [63:0] lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/cenn_fx_mul.sv
// Registered fixed-point multiplier: full-width product, floor shift by FRAC,
// saturated back to WIDTH bits. One cycle of latency, no reset on data.
module cenn_fx_mul
  import cenn_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int FRAC  = FX_FRAC
) (
  input  logic                    clk,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] prod;

  function automatic logic signed [WIDTH-1:0] shift_sat(input logic signed [2*WIDTH-1:0] v);
    return WIDTH'(sat(64'(v) >>> FRAC, WIDTH));
  endfunction

  always_comb begin
    prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  end

  always_ff @(posedge clk) begin
    p <= shift_sat(prod);
  end

endmodule

// File: rtl/cenn_cell.sv
// One CeNN cell update x(n+1) = x(n) + h*(-x + A*y + B*u + I) as a fixed
// nine-stage pipeline with saturating arithmetic and a writable template.
module cenn_cell
  import cenn_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int FRAC  = FX_FRAC,
  parameter int EPS   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [9*WIDTH-1:0]      u_in,
  input  logic [9*WIDTH-1:0]      y_in,
  input  logic                    tpl_wr,
  input  logic [4:0]              tpl_addr,
  input  logic signed [WIDTH-1:0] tpl_data,
  output logic                    tpl_err,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] u_out,
  output logic                    settled
);

  localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(fx_one(FRAC));

  function automatic logic signed [WIDTH-1:0] add_sat(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    return WIDTH'(sat(64'(a) + 64'(b), WIDTH));
  endfunction

  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] a);
    return WIDTH'(sat(-64'(a), WIDTH));
  endfunction

  function automatic logic signed [WIDTH-1:0] clamp_unit(input logic signed [WIDTH-1:0] a);
    return WIDTH'(clamp(64'(a), 64'(ONE_W)));
  endfunction

  logic signed [WIDTH-1:0] tpl_a [9];
  logic signed [WIDTH-1:0] tpl_b [9];
  logic signed [WIDTH-1:0] tpl_i;
  logic signed [WIDTH-1:0] tpl_h;
  logic [3:0]              a_idx;
  logic [3:0]              b_idx;

  logic signed [WIDTH-1:0] u_k [9];
  logic signed [WIDTH-1:0] y_k [9];

  logic signed [WIDTH-1:0] prod_p1 [19];
  logic signed [WIDTH-1:0] neg_x_p1;
  logic signed [WIDTH-1:0] term_p1 [20];
  logic signed [WIDTH-1:0] sum_p2 [10];
  logic signed [WIDTH-1:0] sum_p3 [5];
  logic signed [WIDTH-1:0] sum_p4 [3];
  logic signed [WIDTH-1:0] sum_p5 [2];
  logic signed [WIDTH-1:0] f_p6;
  logic signed [WIDTH-1:0] hf_p7;
  logic signed [WIDTH-1:0] x_p8;
  logic signed [WIDTH-1:0] x_pipe [1:8];
  logic signed [WIDTH-1:0] u_pipe [1:8];

  logic vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6, vld_p7, vld_p8;
  logic signed [63:0] delta_p8;
  logic               settle_p8;

  always_comb begin
    a_idx = tpl_addr[3:0];
    b_idx = 4'(tpl_addr - 5'(TPL_B0));
    for (int k = 0; k < 9; k++) begin
      u_k[k] = u_in[k*WIDTH +: WIDTH];
      y_k[k] = y_in[k*WIDTH +: WIDTH];
    end
    for (int k = 0; k < 19; k++) term_p1[k] = prod_p1[k];
    term_p1[19] = neg_x_p1;
    delta_p8  = 64'(x_p8) - 64'(x_pipe[8]);
    settle_p8 = (delta_p8 <= 64'(EPS)) && (delta_p8 >= -64'(EPS));
  end

  assign busy = vld_p1 | vld_p2 | vld_p3 | vld_p4 | vld_p5 | vld_p6 | vld_p7 | vld_p8 | out_valid;

  // Writes are refused whenever a sample could still be reading the template.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) begin
        tpl_a[k] <= '0;
        tpl_b[k] <= '0;
      end
      tpl_i   <= '0;
      tpl_h   <= ONE_W;
      tpl_err <= 1'b0;
    end else begin
      tpl_err <= 1'b0;
      if (tpl_wr && tpl_addr <= 5'(TPL_LAST)) begin
        if (busy || in_valid) tpl_err <= 1'b1;
        else if (tpl_addr < 5'(TPL_B0)) tpl_a[a_idx] <= tpl_data;
        else if (tpl_addr < 5'(TPL_I)) tpl_b[b_idx] <= tpl_data;
        else if (tpl_addr == 5'(TPL_I)) tpl_i <= tpl_data;
        else if (tpl_addr == 5'(TPL_H)) tpl_h <= tpl_data;
      end
    end
  end

  // S1: template products and the -x term
  for (genvar k = 0; k < 9; k++) begin : g_mul
    cenn_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_a (
      .clk(clk), .a(tpl_a[k]), .b(y_k[k]), .p(prod_p1[k])
    );
    cenn_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_b (
      .clk(clk), .a(tpl_b[k]), .b(u_k[k]), .p(prod_p1[9+k])
    );
  end

  cenn_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_i (
    .clk(clk), .a(tpl_i), .b(ONE_W), .p(prod_p1[18])
  );

  // S7: h * f
  cenn_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_h (
    .clk(clk), .a(tpl_h), .b(f_p6), .p(hf_p7)
  );

  always_ff @(posedge clk) begin
    neg_x_p1  <= neg_sat(x_in);
    x_pipe[1] <= x_in;
    u_pipe[1] <= u_k[4];
    for (int n = 2; n <= 8; n++) begin
      x_pipe[n] <= x_pipe[n-1];
      u_pipe[n] <= u_pipe[n-1];
    end
    // S2-S6: 20 -> 10 -> 5 -> 3 -> 2 -> 1
    for (int i = 0; i < 10; i++) sum_p2[i] <= add_sat(term_p1[2*i], term_p1[2*i+1]);
    for (int i = 0; i < 5; i++) sum_p3[i] <= add_sat(sum_p2[2*i], sum_p2[2*i+1]);
    sum_p4[0] <= add_sat(sum_p3[0], sum_p3[1]);
    sum_p4[1] <= add_sat(sum_p3[2], sum_p3[3]);
    sum_p4[2] <= sum_p3[4];
    sum_p5[0] <= add_sat(sum_p4[0], sum_p4[1]);
    sum_p5[1] <= sum_p4[2];
    f_p6      <= add_sat(sum_p5[0], sum_p5[1]);
    // S8: state update
    x_p8      <= add_sat(x_pipe[7], hf_p7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6, vld_p7, vld_p8} <= '0;
      out_valid <= 1'b0;
    end else begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      vld_p4    <= vld_p3;
      vld_p5    <= vld_p4;
      vld_p6    <= vld_p5;
      vld_p7    <= vld_p6;
      vld_p8    <= vld_p7;
      out_valid <= vld_p8;
    end
  end

  // S9: output registers, held between valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out   <= '0;
      y_out   <= '0;
      u_out   <= '0;
      settled <= 1'b0;
    end else if (vld_p8) begin
      x_out   <= x_p8;
      y_out   <= clamp_unit(x_p8);
      u_out   <= u_pipe[8];
      settled <= settle_p8;
    end
  end

endmodule

// File: tb/tb_cenn_cell.sv
// Scoreboard bench for cenn_cell: a behavioural model predicts each sample's
// result at issue time; a monitor compares whenever out_valid is presented.
module tb_cenn_cell;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [14:0] x_in = '0;
  logic [134:0]       u_in = '0;
  logic [134:0]       y_in = '0;
  logic               tpl_wr = 1'b0;
  logic [4:0]         tpl_addr = '0;
  logic signed [14:0] tpl_data = '0;
  logic               tpl_err, busy, out_valid, settled;
  logic signed [14:0] y_out, x_out, u_out;

  cenn_cell #(.WIDTH(15), .FRAC(9), .EPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .u_in(u_in),
    .y_in(y_in), .tpl_wr(tpl_wr), .tpl_addr(tpl_addr), .tpl_data(tpl_data),
    .tpl_err(tpl_err), .busy(busy), .out_valid(out_valid), .y_out(y_out),
    .x_out(x_out), .u_out(u_out), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x;
    longint y;
    longint u;
    bit     st;
    int     cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mA[9], mB[9], mI, mH;
  int   cur_u[9], cur_y[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint satw(input longint v);
    if (v > 16383) return 16383;
    if (v < -16384) return -16384;
    return v;
  endfunction

  function automatic longint fxm(input longint a, input longint b);
    return satw((a * b) >>> 9);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      mA[k] = 0;
      mB[k] = 0;
    end
    mI = 0;
    mH = 512;
  endtask

  task automatic send(input int x);
    exp_t   e;
    longint f, xn;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = 15'(x);
    for (int k = 0; k < 9; k++) begin
      u_in[k*15 +: 15] = 15'(cur_u[k]);
      y_in[k*15 +: 15] = 15'(cur_y[k]);
    end
    f = -longint'(x) + mI;
    for (int k = 0; k < 9; k++) f += fxm(mA[k], cur_y[k]) + fxm(mB[k], cur_u[k]);
    f = satw(f);
    xn = satw(x + fxm(mH, f));
    e.x = xn;
    e.y = (xn > 512) ? 512 : (xn < -512) ? -512 : xn;
    e.u = cur_u[4];
    e.st = ((xn - x) <= 1) && ((xn - x) >= -1);
    e.cyc = cyc + 9;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", busy, 0);
  endtask

  task automatic tpl_write(input int addr, input int data);
    @(negedge clk);
    tpl_wr = 1'b1;
    tpl_addr = 5'(addr);
    tpl_data = 15'(data);
    @(negedge clk);
    tpl_wr = 1'b0;
    chk("tpl_err_on_accepted_write", tpl_err, 0);
    if (addr < 9) mA[addr] = data;
    else if (addr < 18) mB[addr-9] = data;
    else if (addr == 18) mI = data;
    else if (addr == 19) mH = data;
  endtask

  task automatic zero_cur();
    for (int k = 0; k < 9; k++) begin
      cur_u[k] = 0;
      cur_y[k] = 0;
    end
  endtask

  task automatic rand_cur();
    for (int k = 0; k < 9; k++) begin
      cur_u[k] = int'($urandom_range(0, 1024)) - 512;
      cur_y[k] = int'($urandom_range(0, 1024)) - 512;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("x_out", x_out, e.x);
        chk("y_out", y_out, e.y);
        chk("u_out", u_out, e.u);
        chk("settled", settled, e.st);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    model_reset();
    zero_cur();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_x_out", x_out, 0);
    chk("reset_y_out", y_out, 0);
    chk("reset_u_out", u_out, 0);
    chk("reset_settled", settled, 0);
    chk("reset_tpl_err", tpl_err, 0);

    send(0);
    idle();
    chk("busy_after_sample", busy, 1);
    wait_idle();

    tpl_write(4, 1024);
    cur_y[4] = 512;
    send(0);
    idle();
    wait_idle();

    tpl_write(4, 0);
    tpl_write(13, 16383);
    zero_cur();
    cur_u[4] = 16383;
    send(0);
    cur_u[4] = -16384;
    send(0);
    idle();
    wait_idle();

    tpl_write(13, 0);
    zero_cur();
    tpl_write(18, 256);
    send(256);
    idle();
    wait_idle();
    tpl_write(18, 258);
    send(256);
    idle();
    wait_idle();

    // rejected write while a sample is in flight
    send(100);
    @(negedge clk);
    in_valid = 1'b0;
    tpl_wr = 1'b1;
    tpl_addr = 5'd18;
    tpl_data = 15'd0;
    @(negedge clk);
    tpl_wr = 1'b0;
    chk("tpl_err_pulse", tpl_err, 1);
    @(negedge clk);
    chk("tpl_err_one_cycle", tpl_err, 0);
    wait_idle();
    send(100);
    idle();
    wait_idle();
    tpl_write(25, 77);

    tpl_write(18, 0);
    tpl_write(19, 0);
    zero_cur();
    for (int i = 0; i < 20; i++) send(i);
    idle();
    wait_idle();

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 9; k++) begin
        tpl_write(k, int'($urandom_range(0, 512)) - 256);
        tpl_write(9 + k, int'($urandom_range(0, 512)) - 256);
      end
      tpl_write(18, int'($urandom_range(0, 512)) - 256);
      tpl_write(19, int'($urandom_range(0, 2048)) - 1024);
      for (int s = 0; s < 12; s++) begin
        rand_cur();
        send(int'($urandom_range(0, 8000)) - 4000);
        if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      wait_idle();
    end

    // reset with samples in flight: none of them may emerge
    rand_cur();
    for (int s = 0; s < 3; s++) send(int'($urandom_range(0, 2000)) - 1000);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("busy_after_midop_reset", busy, 0);
    chk("x_out_after_midop_reset", x_out, 0);
    rand_cur();
    send(int'($urandom_range(0, 2000)) - 1000);
    idle();

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", q.size(), 0);
    @(negedge clk);
    chk("busy_at_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
